// File: rtl/ipv4_rcv.sv
// ipv4_rcv
// Receive-side IPv4 stage. Parses and validates the IPv4 header of the
// Ethernet payload byte stream. Qualifying UDP datagrams are forwarded
// to udp_rcv as the UDP segment (header plus data) with Ethernet padding
// trimmed. Everything else is discarded and counted.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   ip_axis_*_in/out      input byte stream (tdata/tvalid/tlast, tready out)
//   udp_axis_*_out/in     output UDP segment stream (tready in)
//   src_ip_out            source IP of the current/last accepted datagram
//   udp_len_out           total_length - IHL*4 of the current/last accepted datagram
//   hdr_valid_out         1-cycle pulse, header accepted
//   drop_out              1-cycle pulse, datagram rejected
//   trunc_out             1-cycle pulse, input ended before udp_len bytes forwarded
//   drop_cnt_out          saturating rejected-datagram count
//
// Handshake: on both streams a byte moves only in a cycle where tvalid and
// tready are both high; tvalid never waits on tready, and data/tlast stay
// stable while tvalid is high and tready is low.
module ipv4_rcv #(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8010A,
  parameter bit          CHECK_CSUM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ip_axis_tdata_in,
  input  logic        ip_axis_tvalid_in,
  input  logic        ip_axis_tlast_in,
  output logic        ip_axis_tready_out,
  output logic [7:0]  udp_axis_tdata_out,
  output logic        udp_axis_tvalid_out,
  output logic        udp_axis_tlast_out,
  input  logic        udp_axis_tready_in,
  output logic [31:0] src_ip_out,
  output logic [15:0] udp_len_out,
  output logic        hdr_valid_out,
  output logic        drop_out,
  output logic        trunc_out,
  output logic [15:0] drop_cnt_out
);

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_TRIM    = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  // FSM state register; readable hierarchically for debug.
  state_t      r_state;

  logic [5:0]  r_hcnt;
  logic [3:0]  r_ver;
  logic [3:0]  r_ihl;
  logic [15:0] r_tot_len;
  logic [15:0] r_frag;
  logic [7:0]  r_proto;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [7:0]  r_csum_hi;
  logic [15:0] r_csum;
  logic [15:0] r_remain;

  logic [31:0] r_src_ip_out;
  logic [15:0] r_udp_len;
  logic        r_hdr_valid;
  logic        r_drop;
  logic        r_trunc;
  logic [15:0] r_drop_cnt;

  logic        w_in_beat;
  logic [5:0]  w_hlen;
  logic [15:0] w_hlen16;
  logic        w_hdr_last;
  logic [16:0] w_sum17;
  logic [15:0] w_csum_next;
  logic [31:0] w_dst;
  logic        w_accept;
  logic [15:0] w_drop_cnt_inc;

  // Output stream is a combinational pass-through while in PAYLOAD.
  assign udp_axis_tdata_out  = ip_axis_tdata_in;
  assign udp_axis_tvalid_out = (r_state == S_PAYLOAD) && ip_axis_tvalid_in;
  assign udp_axis_tlast_out  = (r_state == S_PAYLOAD) &&
                               ((r_remain == 16'd1) || ip_axis_tlast_in);
  assign ip_axis_tready_out  = (r_state == S_PAYLOAD) ? udp_axis_tready_in : 1'b1;

  assign w_in_beat = ip_axis_tvalid_in && ip_axis_tready_out;

  // A header with IHL<5 is still walked as 20 bytes so that all fixed
  // fields are seen; the accept test rejects it anyway.
  assign w_hlen   = (r_ihl < 4'd5) ? 6'd20 : {r_ihl, 2'b00};
  assign w_hlen16 = {10'd0, w_hlen};

  // hcnt==0 is byte 0, where r_ihl is not yet loaded; it is never last.
  assign w_hdr_last = (r_state == S_HDR) && (r_hcnt != 6'd0) &&
                      (r_hcnt == w_hlen - 6'd1);

  // One's-complement add of the word completed by the current (odd) byte.
  assign w_sum17     = {1'b0, r_csum} + {1'b0, r_csum_hi, ip_axis_tdata_in};
  assign w_csum_next = w_sum17[15:0] + {15'd0, w_sum17[16]};

  // With IHL=5 the last dst byte is the deciding beat itself.
  assign w_dst = (r_hcnt == 6'd19) ? {r_dst[23:0], ip_axis_tdata_in} : r_dst;

  assign w_accept = (r_ver == 4'd4) && (r_ihl >= 4'd5) &&
                    (r_proto == 8'd17) &&
                    (r_frag[13:0] == 14'd0) &&
                    ((w_dst == LOCAL_IP) || (w_dst == 32'hFFFFFFFF)) &&
                    (r_tot_len >= w_hlen16 + 16'd8) &&
                    ((w_csum_next == 16'hFFFF) || !CHECK_CSUM);

  assign w_drop_cnt_inc = (r_drop_cnt == 16'hFFFF) ? r_drop_cnt : r_drop_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_HDR;
      r_hcnt       <= '0;
      r_ver        <= '0;
      r_ihl        <= '0;
      r_tot_len    <= '0;
      r_frag       <= '0;
      r_proto      <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_csum_hi    <= '0;
      r_csum       <= '0;
      r_remain     <= '0;
      r_src_ip_out <= '0;
      r_udp_len    <= '0;
      r_hdr_valid  <= 1'b0;
      r_drop       <= 1'b0;
      r_trunc      <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_hdr_valid <= 1'b0;
      r_drop      <= 1'b0;
      r_trunc     <= 1'b0;

      case (r_state)
        S_HDR: begin
          if (w_in_beat) begin
            case (r_hcnt)
              6'd0:  begin
                r_ver <= ip_axis_tdata_in[7:4];
                r_ihl <= ip_axis_tdata_in[3:0];
              end
              6'd2:  r_tot_len[15:8] <= ip_axis_tdata_in;
              6'd3:  r_tot_len[7:0]  <= ip_axis_tdata_in;
              6'd6:  r_frag[15:8]    <= ip_axis_tdata_in;
              6'd7:  r_frag[7:0]     <= ip_axis_tdata_in;
              6'd9:  r_proto         <= ip_axis_tdata_in;
              6'd12, 6'd13, 6'd14, 6'd15:
                r_src <= {r_src[23:0], ip_axis_tdata_in};
              6'd16, 6'd17, 6'd18, 6'd19:
                r_dst <= {r_dst[23:0], ip_axis_tdata_in};
              default: ;
            endcase

            if (!r_hcnt[0]) r_csum_hi <= ip_axis_tdata_in;
            else            r_csum    <= w_csum_next;

            if (w_hdr_last) begin
              r_hcnt <= '0;
              r_csum <= '0;
              if (w_accept && !ip_axis_tlast_in) begin
                r_remain     <= r_tot_len - w_hlen16;
                r_udp_len    <= r_tot_len - w_hlen16;
                r_src_ip_out <= r_src;
                r_hdr_valid  <= 1'b1;
                r_state      <= S_PAYLOAD;
              end else if (w_accept) begin
                // Header good but no payload follows.
                r_trunc <= 1'b1;
              end else begin
                r_drop     <= 1'b1;
                r_drop_cnt <= w_drop_cnt_inc;
                r_state    <= ip_axis_tlast_in ? S_HDR : S_DROP;
              end
            end else if (ip_axis_tlast_in) begin
              // Frame ended inside the header.
              r_hcnt     <= '0;
              r_csum     <= '0;
              r_drop     <= 1'b1;
              r_drop_cnt <= w_drop_cnt_inc;
            end else begin
              r_hcnt <= r_hcnt + 6'd1;
            end
          end
        end

        S_PAYLOAD: begin
          if (w_in_beat) begin
            r_remain <= r_remain - 16'd1;
            if (r_remain == 16'd1) begin
              r_state <= ip_axis_tlast_in ? S_HDR : S_TRIM;
            end else if (ip_axis_tlast_in) begin
              r_trunc <= 1'b1;
              r_state <= S_HDR;
            end
          end
        end

        S_TRIM, S_DROP: begin
          if (w_in_beat && ip_axis_tlast_in) r_state <= S_HDR;
        end

        default: r_state <= S_HDR;
      endcase
    end
  end

  assign src_ip_out    = r_src_ip_out;
  assign udp_len_out   = r_udp_len;
  assign hdr_valid_out = r_hdr_valid;
  assign drop_out      = r_drop;
  assign trunc_out     = r_trunc;
  assign drop_cnt_out  = r_drop_cnt;

endmodule

// File: tb/tb_ipv4_rcv.sv
// Testbench for ipv4_rcv: directed datagrams followed by randomized ones,
// checked against a byte-level reference model of the receive rules.
module tb_ipv4_rcv;

  localparam logic [31:0] LIP   = 32'hC0A8010A;
  localparam logic [31:0] BCAST = 32'hFFFFFFFF;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ip_axis_tdata_in;
  logic        ip_axis_tvalid_in;
  logic        ip_axis_tlast_in;
  logic        ip_axis_tready_out;
  logic [7:0]  udp_axis_tdata_out;
  logic        udp_axis_tvalid_out;
  logic        udp_axis_tlast_out;
  logic        udp_axis_tready_in;
  logic [31:0] src_ip_out;
  logic [15:0] udp_len_out;
  logic        hdr_valid_out;
  logic        drop_out;
  logic        trunc_out;
  logic [15:0] drop_cnt_out;

  always #5 clk = ~clk;

  ipv4_rcv #(.LOCAL_IP(LIP), .CHECK_CSUM(1'b1)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ip_axis_tdata_in    (ip_axis_tdata_in),
    .ip_axis_tvalid_in   (ip_axis_tvalid_in),
    .ip_axis_tlast_in    (ip_axis_tlast_in),
    .ip_axis_tready_out  (ip_axis_tready_out),
    .udp_axis_tdata_out  (udp_axis_tdata_out),
    .udp_axis_tvalid_out (udp_axis_tvalid_out),
    .udp_axis_tlast_out  (udp_axis_tlast_out),
    .udp_axis_tready_in  (udp_axis_tready_in),
    .src_ip_out          (src_ip_out),
    .udp_len_out         (udp_len_out),
    .hdr_valid_out       (hdr_valid_out),
    .drop_out            (drop_out),
    .trunc_out           (trunc_out),
    .drop_cnt_out        (drop_cnt_out)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [7:0]  pkt[$];
  logic [8:0]  exp_q[$];      // {tlast, data}
  int          exp_hdr, exp_drop, exp_trunc;
  logic [31:0] exp_src = '0;
  logic [15:0] exp_len = '0;
  logic [15:0] exp_dcnt = '0;
  int          n_hdr, n_drop, n_trunc;
  int          ready_mode = 0;
  bit          gaps_en = 1'b0;

  // Downstream ready: 0 always ready, 1 toggle, 2 random.
  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       udp_axis_tready_in = 1'b1;
      1:       udp_axis_tready_in = ~udp_axis_tready_in;
      default: udp_axis_tready_in = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard; inputs change just after posedge, so a beat seen
  // here completes at the following posedge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset) begin
      if (hdr_valid_out) n_hdr++;
      if (drop_out)      n_drop++;
      if (trunc_out)     n_trunc++;
      if (udp_axis_tvalid_out) begin
        chk("tready_mirror", 32'(ip_axis_tready_out), 32'(udp_axis_tready_in));
        if (udp_axis_tready_in) begin
          if (exp_q.size() == 0) begin
            chk("spurious_beat", 32'(udp_axis_tvalid_out), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_byte", 32'({udp_axis_tlast_out, udp_axis_tdata_out}), 32'(e));
          end
        end
      end
    end
  end

  // ---------------- packet construction ----------------
  task automatic build(input int ihl, input int tl, input int proto, input int frag,
                       input logic [31:0] dst, input int n_after, input logic [15:0] csum_xor);
    int          hlen;
    logic [31:0] sum;
    logic [31:0] src;
    logic [15:0] csum;
    logic [7:0]  b0;
    hlen = ihl * 4;
    src  = $urandom;
    b0   = 8'((4 << 4) | ihl);
    pkt.delete();
    pkt.push_back(b0);
    pkt.push_back(8'($urandom));
    pkt.push_back(8'(tl >> 8));  pkt.push_back(8'(tl));
    pkt.push_back(8'($urandom)); pkt.push_back(8'($urandom));
    pkt.push_back(8'(frag >> 8)); pkt.push_back(8'(frag));
    pkt.push_back(8'd64);
    pkt.push_back(8'(proto));
    pkt.push_back(8'd0); pkt.push_back(8'd0);
    for (int i = 3; i >= 0; i--) pkt.push_back(8'(src >> (8 * i)));
    for (int i = 3; i >= 0; i--) pkt.push_back(8'(dst >> (8 * i)));
    for (int i = 20; i < hlen; i++) pkt.push_back(8'($urandom));
    sum = 0;
    for (int i = 0; i < hlen; i += 2) begin
      sum = sum + {16'd0, pkt[i], pkt[i+1]};
      if (sum > 32'hFFFF) sum = sum - 32'hFFFF;
    end
    csum = ~sum[15:0] ^ csum_xor;
    pkt[10] = csum[15:8];
    pkt[11] = csum[7:0];
    for (int i = 0; i < n_after; i++) pkt.push_back(8'($urandom));
  endtask

  // Reference model: what the receiver must do with the whole of pkt.
  task automatic model();
    int          n, ver, ihl, hlen, tl, frag, proto, ulen, avail, nf;
    logic [31:0] dst, src, sum;
    bit          ok;
    exp_hdr = 0; exp_drop = 0; exp_trunc = 0;
    n    = pkt.size();
    ver  = int'(pkt[0] >> 4);
    ihl  = int'(pkt[0] & 8'h0F);
    hlen = (ihl < 5 ? 5 : ihl) * 4;
    if (n < hlen) begin
      exp_drop = 1;
    end else begin
      tl    = int'({pkt[2], pkt[3]});
      frag  = int'({pkt[6], pkt[7]});
      proto = int'(pkt[9]);
      src   = {pkt[12], pkt[13], pkt[14], pkt[15]};
      dst   = {pkt[16], pkt[17], pkt[18], pkt[19]};
      sum   = 0;
      for (int i = 0; i < hlen; i += 2) begin
        sum = sum + {16'd0, pkt[i], pkt[i+1]};
        if (sum > 32'hFFFF) sum = sum - 32'hFFFF;
      end
      ok = (ver == 4) && (ihl >= 5) && (proto == 17) && ((frag & 32'h3FFF) == 0) &&
           (dst == LIP || dst == BCAST) && (tl >= ihl * 4 + 8) && (sum == 32'hFFFF);
      if (!ok) begin
        exp_drop = 1;
      end else if (n == hlen) begin
        exp_trunc = 1;
      end else begin
        exp_hdr   = 1;
        ulen      = tl - hlen;
        exp_src   = src;
        exp_len   = 16'(ulen);
        avail     = n - hlen;
        nf        = (avail < ulen) ? avail : ulen;
        exp_trunc = (avail < ulen) ? 1 : 0;
        for (int i = 0; i < nf; i++) exp_q.push_back({(i == nf - 1), pkt[hlen + i]});
      end
    end
    if (exp_drop != 0 && exp_dcnt != 16'hFFFF) exp_dcnt = exp_dcnt + 16'd1;
  endtask

  // ---------------- driver ----------------
  task automatic send(input int n);
    bit got;
    int budget;
    for (int i = 0; i < n; i++) begin
      if (gaps_en) begin
        while ($urandom_range(0, 3) == 0) begin
          ip_axis_tvalid_in = 1'b0;
          @(posedge clk); #1;
        end
      end
      ip_axis_tdata_in  = pkt[i];
      ip_axis_tlast_in  = (i == pkt.size() - 1);
      ip_axis_tvalid_in = 1'b1;
      got = 1'b0;
      budget = 0;
      while (!got && budget < 2000) begin
        @(negedge clk);
        got = ip_axis_tready_out;
        @(posedge clk); #1;
        budget++;
      end
      if (!got) begin
        chk("tready_timeout", 32'(ip_axis_tready_out), 32'd1);
        ip_axis_tvalid_in = 1'b0;
        ip_axis_tlast_in  = 1'b0;
        return;
      end
    end
    ip_axis_tvalid_in = 1'b0;
    ip_axis_tlast_in  = 1'b0;
  endtask

  task automatic run_pkt(input string tag);
    n_hdr = 0; n_drop = 0; n_trunc = 0;
    model();
    send(pkt.size());
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_hdr_valid"}, 32'(n_hdr), 32'(exp_hdr));
    chk({tag, "_drop"}, 32'(n_drop), 32'(exp_drop));
    chk({tag, "_trunc"}, 32'(n_trunc), 32'(exp_trunc));
    chk({tag, "_drop_cnt"}, 32'(drop_cnt_out), 32'(exp_dcnt));
    chk({tag, "_src_ip"}, src_ip_out, exp_src);
    chk({tag, "_udp_len"}, 32'(udp_len_out), 32'(exp_len));
    exp_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int ihl, tl, ulen, sel, keep;
    logic [31:0] dst;
    reset = 1'b1;
    ip_axis_tdata_in = '0;
    ip_axis_tvalid_in = 1'b0;
    ip_axis_tlast_in = 1'b0;
    udp_axis_tready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_tvalid", 32'(udp_axis_tvalid_out), 32'd0);
    chk("rst_tready", 32'(ip_axis_tready_out), 32'd1);
    chk("rst_hdr_valid", 32'(hdr_valid_out), 32'd0);
    chk("rst_drop", 32'(drop_out), 32'd0);
    chk("rst_trunc", 32'(trunc_out), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt_out), 32'd0);
    chk("rst_src", src_ip_out, 32'd0);
    chk("rst_len", 32'(udp_len_out), 32'd0);
    @(posedge clk); #1;

    build(5, 36, 17, 0, LIP, 26, 16'h0);        run_pkt("valid");
    chk("valid_len16", 32'(udp_len_out), 32'd16);
    build(5, 36, 17, 0, LIP, 26, 16'h1);        run_pkt("bad_csum");
    build(5, 36, 17, 0, LIP, 16, 16'h0);        run_pkt("after_bad");
    build(5, 36, 6, 0, LIP, 16, 16'h0);         run_pkt("proto6");
    build(5, 36, 17, 16'h2000, LIP, 16, 16'h0); run_pkt("mf");
    build(5, 36, 17, 0, 32'h0A000001, 16, 16'h0); run_pkt("dst_other");
    build(5, 36, 17, 0, BCAST, 16, 16'h0);      run_pkt("bcast");
    chk("filters_drop_cnt", 32'(drop_cnt_out), 32'd4);
    build(6, 32, 17, 0, LIP, 12, 16'h0);        run_pkt("ihl6");
    ready_mode = 1;
    build(5, 36, 17, 0, LIP, 20, 16'h0);        run_pkt("toggle");
    ready_mode = 0;
    build(5, 36, 17, 0, LIP, 5, 16'h0);         run_pkt("trunc5");
    build(5, 36, 17, 0, LIP, 16, 16'h0);        run_pkt("after_trunc");
    build(5, 36, 17, 0, LIP, 16, 16'h0);
    while (pkt.size() > 10) void'(pkt.pop_back());
    run_pkt("short_hdr");
    build(5, 36, 17, 0, LIP, 0, 16'h0);         run_pkt("hdr_only");
    build(5, 36, 17, 16'h4000, LIP, 16, 16'h0); run_pkt("df_ok");

    // Randomized datagrams with random gaps and downstream backpressure.
    ready_mode = 2;
    gaps_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      ihl  = $urandom_range(5, 7);
      tl   = ihl * 4 + 8 + $urandom_range(0, 20);
      ulen = tl - ihl * 4;
      sel  = $urandom_range(0, 5);
      dst  = (sel == 0) ? BCAST : (sel == 1) ? 32'h0A000001 : LIP;
      build(ihl, tl, ($urandom_range(0, 5) == 0) ? 6 : 17,
            ($urandom_range(0, 5) == 0) ? 16'h2000 : 16'h4000 * $urandom_range(0, 1),
            dst, $urandom_range(0, ulen + 10),
            ($urandom_range(0, 5) == 0) ? 16'h0100 : 16'h0);
      if ($urandom_range(0, 7) == 0) begin
        keep = $urandom_range(1, ihl * 4 - 1);
        while (pkt.size() > keep) void'(pkt.pop_back());
      end
      run_pkt("rand");
    end
    ready_mode = 0;
    gaps_en = 1'b0;

    // Reset in the middle of a payload.
    n_hdr = 0; n_drop = 0; n_trunc = 0;
    build(5, 36, 17, 0, LIP, 26, 16'h0);
    model();
    send(24);
    reset = 1'b1;
    ip_axis_tvalid_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_dcnt = '0;
    exp_src  = '0;
    exp_len  = '0;
    ip_axis_tdata_in  = pkt[24];
    ip_axis_tvalid_in = 1'b1;
    #1;
    chk("midrst_tvalid", 32'(udp_axis_tvalid_out), 32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt_out), 32'd0);
    chk("midrst_src", src_ip_out, 32'd0);
    ip_axis_tvalid_in = 1'b0;
    @(posedge clk); #1;
    build(5, 36, 17, 0, LIP, 26, 16'h0);        run_pkt("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
